// File: rtl/di_bus_arbiter_if.sv
// Host-side and device-side signal bundle of the di register bus arbiter.
// The arbiter connects through the slave modport; the surrounding hosts/device use master.
interface di_bus_arbiter_if #(
  parameter int N = 2
);
  // Handshake: a master holds its mode level for a whole transaction and issues
  // one-cycle strobes; a strobe completes only while the matching m_*_rdy is high,
  // and m_*_rdy stays low until that master owns the bus.
  logic [16*N-1:0] m_term_addr;
  logic [32*N-1:0] m_reg_addr;
  logic [32*N-1:0] m_len;
  logic [32*N-1:0] m_reg_datai;
  logic [N-1:0]    m_read_mode;
  logic [N-1:0]    m_write_mode;
  logic [N-1:0]    m_read_req;
  logic [N-1:0]    m_read;
  logic [N-1:0]    m_write;
  logic [N-1:0]    m_read_rdy;
  logic [N-1:0]    m_write_rdy;
  logic [31:0]     m_reg_datao;
  logic [16*N-1:0] m_transfer_status;

  logic [15:0]     di_term_addr;
  logic [31:0]     di_reg_addr;
  logic [31:0]     di_len;
  logic [31:0]     di_reg_datai;
  logic            di_read_mode;
  logic            di_write_mode;
  logic            di_read_req;
  logic            di_read;
  logic            di_write;
  logic            di_read_rdy;
  logic            di_write_rdy;
  logic [31:0]     di_reg_datao;
  logic [15:0]     di_transfer_status;

  logic            grant_valid;
  logic [2:0]      grant_id;
  logic [1:0]      dbg_state;

  modport slave (
    input  m_term_addr, m_reg_addr, m_len, m_reg_datai,
    input  m_read_mode, m_write_mode, m_read_req, m_read, m_write,
    output m_read_rdy, m_write_rdy, m_reg_datao, m_transfer_status,
    output di_term_addr, di_reg_addr, di_len, di_reg_datai,
    output di_read_mode, di_write_mode, di_read_req, di_read, di_write,
    input  di_read_rdy, di_write_rdy, di_reg_datao, di_transfer_status,
    output grant_valid, grant_id, dbg_state
  );

  modport master (
    output m_term_addr, m_reg_addr, m_len, m_reg_datai,
    output m_read_mode, m_write_mode, m_read_req, m_read, m_write,
    input  m_read_rdy, m_write_rdy, m_reg_datao, m_transfer_status,
    input  di_term_addr, di_reg_addr, di_len, di_reg_datai,
    input  di_read_mode, di_write_mode, di_read_req, di_read, di_write,
    output di_read_rdy, di_write_rdy, di_reg_datao, di_transfer_status,
    input  grant_valid, grant_id, dbg_state
  );
endinterface

// File: rtl/di_bus_arbiter.sv
// Round-robin arbiter sharing one di register bus between N host masters,
// with latching and replay of strobes a master issues while it is blocked.
module di_bus_arbiter #(
  parameter int N          = 2,
  parameter int GAP_CYCLES = 1
) (
  input logic               clk,
  input logic               reset_n,
  di_bus_arbiter_if.slave   bus
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_OWN  = 2'd1,
    ST_GAP  = 2'd2
  } state_t;

  state_t       r_state;
  logic         r_grant_valid;
  logic [2:0]   r_grant_id;
  logic [2:0]   r_last_grant;
  logic [3:0]   r_gap_cnt;
  logic [N-1:0] r_pend_rreq;
  logic [N-1:0] r_pend_rd;
  logic [N-1:0] r_pend_wr;

  logic [N-1:0] w_active;
  logic [N-1:0] w_sel;
  logic         w_any;
  logic         w_owner_active;
  logic [2:0]   w_pick;
  logic [2:0]   w_pick_lo;
  logic [2:0]   w_pick_hi;
  logic         w_hi_found;

  assign w_active       = bus.m_read_mode | bus.m_write_mode;
  assign w_any          = |w_active;
  assign w_owner_active = |(w_active & w_sel);

  // Round-robin: first active index above the last grant, else wrap to the lowest.
  always_comb begin
    w_pick_lo  = 3'd0;
    w_pick_hi  = 3'd0;
    w_hi_found = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (w_active[i]) begin
        w_pick_lo = 3'(i);
        if (3'(i) > r_last_grant) begin
          w_pick_hi  = 3'(i);
          w_hi_found = 1'b1;
        end
      end
    end
    w_pick = w_hi_found ? w_pick_hi : w_pick_lo;
  end

  always_comb begin
    w_sel = '0;
    for (int i = 0; i < N; i++) begin
      w_sel[i] = r_grant_valid && (r_grant_id == 3'(i));
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state       <= ST_IDLE;
      r_grant_valid <= 1'b0;
      r_grant_id    <= 3'd0;
      r_last_grant  <= 3'(N - 1);
      r_gap_cnt     <= 4'd0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_any) begin
            r_state       <= ST_OWN;
            r_grant_valid <= 1'b1;
            r_grant_id    <= w_pick;
            r_last_grant  <= w_pick;
          end
        end
        ST_OWN: begin
          if (!w_owner_active) begin
            r_state       <= ST_GAP;
            r_grant_valid <= 1'b0;
            r_gap_cnt     <= 4'(GAP_CYCLES);
          end
        end
        ST_GAP: begin
          // The last gap cycle already arbitrates so the next owner appears right after it.
          if (r_gap_cnt <= 4'd1) begin
            r_gap_cnt <= 4'd0;
            if (w_any) begin
              r_state       <= ST_OWN;
              r_grant_valid <= 1'b1;
              r_grant_id    <= w_pick;
              r_last_grant  <= w_pick;
            end else begin
              r_state <= ST_IDLE;
            end
          end else begin
            r_gap_cnt <= r_gap_cnt - 4'd1;
          end
        end
        default: begin
          r_state       <= ST_IDLE;
          r_grant_valid <= 1'b0;
        end
      endcase
    end
  end

  // Flags clear on the owner's replay cycle and whenever their master goes inactive.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_pend_rreq <= '0;
      r_pend_rd   <= '0;
      r_pend_wr   <= '0;
    end else begin
      for (int i = 0; i < N; i++) begin
        if (!w_active[i] || w_sel[i]) begin
          r_pend_rreq[i] <= 1'b0;
          r_pend_rd[i]   <= 1'b0;
          r_pend_wr[i]   <= 1'b0;
        end else begin
          if (bus.m_read_req[i]) r_pend_rreq[i] <= 1'b1;
          if (bus.m_read[i])     r_pend_rd[i]   <= 1'b1;
          if (bus.m_write[i])    r_pend_wr[i]   <= 1'b1;
        end
      end
    end
  end

  logic [15:0]     w_term_addr;
  logic [31:0]     w_reg_addr;
  logic [31:0]     w_len;
  logic [31:0]     w_reg_datai;
  logic            w_read_mode;
  logic            w_write_mode;
  logic            w_read_req;
  logic            w_read;
  logic            w_write;
  logic [N-1:0]    w_read_rdy;
  logic [N-1:0]    w_write_rdy;
  logic [16*N-1:0] w_status;

  always_comb begin
    w_term_addr  = 16'h0;
    w_reg_addr   = 32'h0;
    w_len        = 32'h0;
    w_reg_datai  = 32'h0;
    w_read_mode  = 1'b0;
    w_write_mode = 1'b0;
    w_read_req   = 1'b0;
    w_read       = 1'b0;
    w_write      = 1'b0;
    w_read_rdy   = '0;
    w_write_rdy  = '0;
    w_status     = '0;
    for (int i = 0; i < N; i++) begin
      if (w_sel[i]) begin
        w_term_addr  = bus.m_term_addr[16*i +: 16];
        w_reg_addr   = bus.m_reg_addr[32*i +: 32];
        w_len        = bus.m_len[32*i +: 32];
        w_reg_datai  = bus.m_reg_datai[32*i +: 32];
        w_read_mode  = bus.m_read_mode[i];
        w_write_mode = bus.m_write_mode[i];
        w_read_req   = bus.m_read_req[i] | r_pend_rreq[i];
        w_read       = bus.m_read[i]     | r_pend_rd[i];
        w_write      = bus.m_write[i]    | r_pend_wr[i];
        w_read_rdy[i]         = bus.di_read_rdy;
        w_write_rdy[i]        = bus.di_write_rdy;
        w_status[16*i +: 16]  = bus.di_transfer_status;
      end
    end
  end

  assign bus.di_term_addr      = w_term_addr;
  assign bus.di_reg_addr       = w_reg_addr;
  assign bus.di_len            = w_len;
  assign bus.di_reg_datai      = w_reg_datai;
  assign bus.di_read_mode      = w_read_mode;
  assign bus.di_write_mode     = w_write_mode;
  assign bus.di_read_req       = w_read_req;
  assign bus.di_read           = w_read;
  assign bus.di_write          = w_write;
  assign bus.m_read_rdy        = w_read_rdy;
  assign bus.m_write_rdy       = w_write_rdy;
  assign bus.m_transfer_status = w_status;
  assign bus.m_reg_datao       = bus.di_reg_datao;
  assign bus.grant_valid       = r_grant_valid;
  assign bus.grant_id          = r_grant_id;
  assign bus.dbg_state         = r_state;

endmodule
